mul_issue: RTL and testbench
============================

# mul_issue

Issue/retire controller sitting directly upstream of the `mul` unit in the NPC execute stage. Accepts one multiply op at a time from EXU decode and performs RV64 operand preparation for MUL/MULW. Drives the `mul` request handshake, waits for its result, and sign-extends MULW results. Holds the formatted result until the write-back side takes it. Propagates pipeline flush to `mul` and abandons the in-flight op.

## Interface
- No parameters; datapath fixed at 64 bits.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: decode presents an op.
- `in_ready` out 1: controller can accept an op.
- `in_op` in 2: 00 = MUL, 01 = MULW, 1x = reserved, treated as MUL.
- `in_src1`, `in_src2` in 64: rs1/rs2 values.
- `in_rd` in 5: destination register tag.
- `flush` in 1: pipeline flush.
- `mul_valid` out 1: request to `mul`.
- `mul_flush` out 1: flush to `mul`.
- `mul_signed` out 2: operand signedness to `mul`.
- `mul_multiplicand`, `mul_multiplier` out 64: operands to `mul`.
- `mul_ready` in 1: `mul` accepts the request.
- `mul_out_valid` in 1: `mul` result valid.
- `mul_result_lo` in 64: low 64 bits of product.
- `out_valid` out 1: formatted result available.
- `out_ready` in 1: write-back accepts the result.
- `out_result` out 64: formatted result.
- `out_rd` out 5: tag of the result.
- `busy` out 1: op in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE; async reset to IDLE.
- IDLE:
  - `in_ready = ~flush`.
  - On `in_valid & in_ready`: register operands, op and rd; go to ISSUE.
- Operand prep at capture:
  - MUL: operands passed unchanged.
  - MULW: each operand = sign-extension of its bits [31:0].
- ISSUE: `mul_valid = 1`.
  - `mul_ready & mul_out_valid` in the same cycle: capture result, go to DONE.
  - `mul_ready` alone: go to WAIT.
- WAIT: on `mul_out_valid`, capture result, go to DONE.
- DONE: `out_valid = 1`; on `out_ready`, go to IDLE.
- Result formatting at capture:
  - MUL: `mul_result_lo`.
  - MULW: `{{32{r[31]}}, r[31:0]}`.
- `mul_signed` is constant 2'b11; the low 64 bits are sign-independent.
- `mul_multiplicand`/`mul_multiplier` come straight from the operand registers and are stable from ISSUE until the result is captured.
- `mul_flush = flush`, combinational.
- Flush in any state:
  - Next state is IDLE.
  - No op is accepted that cycle.
  - `out_valid` is deasserted from the next cycle on.
  - A `mul_out_valid` arriving in the same cycle is discarded.
- `mul_out_valid` is ignored in IDLE and DONE.
- `in_valid` is ignored whenever the state is not IDLE.

## Timing
- Reset values: state IDLE; `mul_valid`, `out_valid`, `busy` = 0; `out_result`, `out_rd` and operand registers = 0.
- `in_ready` = 1 once reset is released, unless `flush` is high.
- Accept at edge T: `mul_valid` high during cycle T+1.
- Minimum latency, accept to `out_valid`:
  - 2 cycles when `mul_ready` and `mul_out_valid` are high together in ISSUE.
  - Otherwise 2 cycles plus the `mul` latency.
- `out_result`/`out_rd` are registered and stable while `out_valid` is high.
- Back-to-back throughput: the earliest next accept is the cycle after the DONE handshake. IDLE is mandatory between ops.
- `reset` asserted mid-op: immediate return to IDLE; outputs take reset values asynchronously.

## Configuration
- `MUL_ISSUE_ZERO_SKIP_EN` defined:
  - If either prepared operand is zero at capture, go IDLE → DONE directly with result 0.
  - `mul_valid` is never asserted for that op.
  - `out_valid` rises the cycle after accept.
- Macro undefined: every op goes through ISSUE/WAIT, with no zero detection logic.

## Test plan
- MUL: src1=0x3, src2=0xFFFF_FFFF_FFFF_FFFE, `mul_result_lo`=0xFFFF_FFFF_FFFF_FFFA after 4 WAIT cycles -> `out_result`=0xFFFF_FFFF_FFFF_FFFA, rd echoed, `out_valid` held until `out_ready`.
- MULW: src1=0x1_8000_0000, src2=0x2 -> operands driven as 0xFFFF_FFFF_8000_0000 and 0x2; with `mul_result_lo`=0xFFFF_FFFF_0000_0000 -> `out_result`=0x0.
- `mul_ready` low for 3 cycles: `mul_valid` and operands hold steady, `in_ready`=0 throughout, `busy`=1.
- `flush` during WAIT with `mul_out_valid` in the same cycle -> `mul_flush`=1, result discarded, IDLE next cycle, `out_valid` never rises, a new op is accepted the following cycle.
- `out_ready` low for 5 cycles in DONE -> `out_result` is unchanged and `in_valid` is ignored. After `out_ready`=1, `in_ready`=1 on the next cycle.
- With `MUL_ISSUE_ZERO_SKIP_EN`: src2=0 -> `out_valid` in cycle T+1 with result 0 and `mul_valid` never high. Without the macro the same op goes through ISSUE.

Source files
------------

// File: rtl/mul_issue.sv
// mul_issue: issue/retire controller in front of the execute-stage `mul` unit.
// Takes one MUL/MULW op at a time from decode and prepares the RV64 operands.
// It then runs the request handshake with `mul`, waits for the product and
// formats the result (MULW results are sign-extended). The result is held
// until write-back takes it.
// A pipeline flush is passed on to `mul` and abandons the op in flight.
//
// Optional feature, selected by the macro MUL_ISSUE_ZERO_SKIP_EN: when either
// prepared operand is zero at capture, the op skips `mul` entirely and
// completes with a zero result on the cycle after it is accepted.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The side raising valid holds it, and keeps its payload
// stable, until that edge. Ready may depend combinationally on valid.
// Three handshakes use this rule:
//   in_valid/in_ready   decode -> controller
//   mul_valid/mul_ready controller -> mul
//   out_valid/out_ready controller -> write-back
// mul_out_valid is a one-cycle strobe from `mul`. It has no back-pressure.
module mul_issue (
  input  logic        clock,
  input  logic        reset,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  // mul unit side
  output logic        mul_valid,
  output logic        mul_flush,
  output logic [1:0]  mul_signed,
  output logic [63:0] mul_multiplicand,
  output logic [63:0] mul_multiplier,
  input  logic        mul_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] mul_result_lo,
  // write-back side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [4:0]  out_rd,
  output logic        busy,
  // current FSM state, for observation only
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OP_MULW = 2'b01;

  logic [1:0]  state;
  logic [1:0]  state_nxt;

  // op context captured at accept
  logic        is_w_q;
  logic [4:0]  rd_q;
  logic [63:0] opa_q;
  logic [63:0] opb_q;

  // formatted result held for write-back
  logic [63:0] res_q;
  logic [4:0]  res_rd_q;

  // operand preparation on the incoming op
  logic        in_is_w;
  logic [63:0] opa_prep;
  logic [63:0] opb_prep;

  // control strobes
  logic        accept;
  logic        capture;
  logic        zero_hit;
  logic [63:0] res_fmt;

  // Reserved encodings 1x fall through as plain MUL.
  assign in_is_w  = (in_op == OP_MULW);
  assign opa_prep = in_is_w ? {{32{in_src1[31]}}, in_src1[31:0]} : in_src1;
  assign opb_prep = in_is_w ? {{32{in_src2[31]}}, in_src2[31:0]} : in_src2;

  // A flush blocks the accept in the same cycle through in_ready.
  assign in_ready = (state == IDLE) & ~flush;
  assign accept   = in_valid & in_ready;

  // A product is taken in ISSUE only together with the request handshake.
  // In WAIT it is taken on the strobe alone. A flush in the same cycle
  // discards it.
  assign capture = ~flush & mul_out_valid &
                   (((state == ISSUE) & mul_ready) | (state == WAIT));

`ifdef MUL_ISSUE_ZERO_SKIP_EN
  // Either zero operand gives a zero low product, so `mul` can be bypassed.
  assign zero_hit = accept & ((opa_prep == 64'd0) | (opb_prep == 64'd0));
`else
  assign zero_hit = 1'b0;
`endif

  // MULW keeps the low word of the product, sign-extended to 64 bits.
  assign res_fmt = is_w_q ? {{32{mul_result_lo[31]}}, mul_result_lo[31:0]}
                          : mul_result_lo;

  // Next-state logic. A flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = zero_hit ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (mul_ready) begin
            state_nxt = mul_out_valid ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mul_out_valid) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Op context and prepared operands. They are loaded only on accept, so they
  // stay stable from ISSUE until the result is captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_w_q <= 1'b0;
      rd_q   <= 5'd0;
      opa_q  <= 64'd0;
      opb_q  <= 64'd0;
    end else if (accept) begin
      is_w_q <= in_is_w;
      rd_q   <= in_rd;
      opa_q  <= opa_prep;
      opb_q  <= opb_prep;
    end
  end

  // Result register. It is loaded from `mul`, or with zero on a skipped op,
  // and held through DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q    <= 64'd0;
      res_rd_q <= 5'd0;
    end else if (zero_hit) begin
      res_q    <= 64'd0;
      res_rd_q <= in_rd;
    end else if (capture) begin
      res_q    <= res_fmt;
      res_rd_q <= rd_q;
    end
  end

  // Outputs decoded from state, plus the pass-through signals.
  always_comb begin
    mul_valid        = (state == ISSUE);
    out_valid        = (state == DONE);
    busy             = (state != IDLE);
    mul_flush        = flush;
    mul_signed       = 2'b11;
    mul_multiplicand = opa_q;
    mul_multiplier   = opb_q;
    out_result       = res_q;
    out_rd           = res_rd_q;
    state_dbg        = state;
  end

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: self-checking bench for mul_issue.
// The bench acts as both decode and the `mul` unit. It runs a table of
// directed vectors, hand-written flush/reset/zero-operand sequences and
// randomized ops. Every result is checked against a reference model that
// works directly from the RV64 arithmetic.
module tb_mul_issue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        mul_valid;
  logic        mul_flush;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_ready;
  logic        mul_out_valid;
  logic [63:0] mul_result_lo;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  mul_issue dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_op            (in_op),
    .in_src1          (in_src1),
    .in_src2          (in_src2),
    .in_rd            (in_rd),
    .flush            (flush),
    .mul_valid        (mul_valid),
    .mul_flush        (mul_flush),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (mul_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_lo    (mul_result_lo),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .busy             (busy),
    .state_dbg        (state_dbg)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // comparison and timing helpers
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // reference model: RV64 MUL/MULW semantics in plain arithmetic
  function automatic logic [63:0] sext32(input logic [63:0] v);
    longint s;
    s = longint'(int'(v[31:0]));
    return 64'(s);
  endfunction

  function automatic logic [63:0] ref_operand(input logic [1:0] op, input logic [63:0] v);
    return (op == 2'b01) ? sext32(v) : v;
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] p;
    p = a * b;
    return (op == 2'b01) ? sext32(p) : p;
  endfunction

  // driver: one full op through the decode, mul and write-back handshakes
  task automatic do_op(input logic [1:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [4:0] rd, input int rdy_dly, input int lat, input int out_dly,
                       input logic [63:0] e_ma, input logic [63:0] e_mb,
                       input logic [63:0] e_res, input string tag);
    in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_rd = rd;
    #1;
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    tick;                                   // accept edge T
    in_valid = 1'b0;
    #1;
    check({tag, " mul_valid T+1"}, 64'(mul_valid), 64'd1);
    check({tag, " multiplicand"}, mul_multiplicand, e_ma);
    check({tag, " multiplier"}, mul_multiplier, e_mb);
    check({tag, " out_valid in issue"}, 64'(out_valid), 64'd0);
    // mul_ready held low for rdy_dly cycles
    for (int i = 0; i < rdy_dly; i++) begin
      in_valid = 1'b1; in_src1 = 64'hdead; in_src2 = 64'hbeef; in_rd = 5'd0;
      tick;
      #1;
      check({tag, " mul_valid hold"}, 64'(mul_valid), 64'd1);
      check({tag, " multiplicand hold"}, mul_multiplicand, e_ma);
      check({tag, " multiplier hold"}, mul_multiplier, e_mb);
      check({tag, " in_ready issue"}, 64'(in_ready), 64'd0);
      check({tag, " busy issue"}, 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    mul_ready = 1'b1;
    mul_out_valid = (lat == 0);
    mul_result_lo = mul_multiplicand * mul_multiplier;
    tick;                                   // request handshake edge
    mul_ready = 1'b0;
    mul_out_valid = 1'b0;
    if (lat > 0) begin
      #1;
      check({tag, " mul_valid wait"}, 64'(mul_valid), 64'd0);
      check({tag, " out_valid wait"}, 64'(out_valid), 64'd0);
      repeat (lat - 1) tick;
      mul_out_valid = 1'b1;
      mul_result_lo = mul_multiplicand * mul_multiplier;
      tick;                                 // result edge
      mul_out_valid = 1'b0;
    end
    #1;
    check({tag, " out_valid done"}, 64'(out_valid), 64'd1);
    check({tag, " out_result"}, out_result, e_res);
    check({tag, " out_rd"}, 64'(out_rd), 64'(rd));
    // write-back stalls, while junk arrives on decode and mul
    for (int i = 0; i < out_dly; i++) begin
      in_valid = 1'b1; in_src1 = 64'h1234; in_src2 = 64'h5678; in_rd = 5'd30;
      mul_out_valid = 1'b1; mul_result_lo = 64'h0bad_0bad_0bad_0bad;
      #1;
      check({tag, " in_ready done"}, 64'(in_ready), 64'd0);
      tick;
      mul_out_valid = 1'b0;
      check({tag, " out_valid held"}, 64'(out_valid), 64'd1);
      check({tag, " out_result held"}, out_result, e_res);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;                                   // write-back handshake edge
    out_ready = 1'b0;
    #1;
    check({tag, " out_valid after wb"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready after wb"}, 64'(in_ready), 64'd1);
  endtask

  // directed vector table
  typedef struct {
    logic [1:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [4:0]  rd;
    int          rdy_dly;
    int          lat;
    int          out_dly;
    logic [63:0] e_ma;
    logic [63:0] e_mb;
    logic [63:0] e_res;
  } vec_t;

  vec_t vt[6];

  // main sequence
  initial begin
    logic [1:0]  r_op;
    logic [63:0] r_s1;
    logic [63:0] r_s2;
    logic [4:0]  r_rd;

    vt[0] = '{2'b00, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd5, 0, 4, 2,
              64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA};
    vt[1] = '{2'b01, 64'h1_8000_0000, 64'h2, 5'd7, 0, 1, 0,
              64'hFFFF_FFFF_8000_0000, 64'h2, 64'h0};
    vt[2] = '{2'b00, 64'h10, 64'h20, 5'd31, 3, 0, 0,
              64'h10, 64'h20, 64'h200};
    vt[3] = '{2'b10, 64'h1_0000_0003, 64'h5, 5'd1, 1, 0, 1,
              64'h1_0000_0003, 64'h5, 64'h5_0000_000F};
    vt[4] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 5'd9, 0, 2, 0,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001};
    vt[5] = '{2'b01, 64'hABCD_0000_0000_FFFF, 64'h1234_0000_0001_0001, 5'd12, 2, 3, 5,
              64'h0000_0000_0000_FFFF, 64'h0000_0000_0001_0001, 64'hFFFF_FFFF_FFFF_FFFF};

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_src1 = 64'd0; in_src2 = 64'd0; in_rd = 5'd0;
    mul_ready = 1'b0; mul_out_valid = 1'b0; mul_result_lo = 64'd0; out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst mul_valid", 64'(mul_valid), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst out_result", out_result, 64'd0);
    check("rst out_rd", 64'(out_rd), 64'd0);
    check("rst multiplicand", mul_multiplicand, 64'd0);
    check("rst multiplier", mul_multiplier, 64'd0);
    check("rst mul_signed", 64'(mul_signed), 64'd3);
    reset = 1'b0;
    tick;
    check("post-rst in_ready", 64'(in_ready), 64'd1);

    // table-driven vectors, issued back to back
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].op, vt[i].s1, vt[i].s2, vt[i].rd, vt[i].rdy_dly, vt[i].lat,
            vt[i].out_dly, vt[i].e_ma, vt[i].e_mb, vt[i].e_res, $sformatf("vec%0d", i));
    end

    // a flush in IDLE blocks the accept
    in_valid = 1'b1; in_op = 2'b00; in_src1 = 64'h9; in_src2 = 64'h9; in_rd = 5'd4;
    flush = 1'b1;
    #1;
    check("idle flush in_ready", 64'(in_ready), 64'd0);
    check("idle flush mul_flush", 64'(mul_flush), 64'd1);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("idle flush busy", 64'(busy), 64'd0);

    // flush in WAIT, with mul_out_valid in the same cycle
    in_valid = 1'b1; in_op = 2'b00; in_src1 = 64'd6; in_src2 = 64'd7; in_rd = 5'd3;
    tick;
    in_valid = 1'b0; mul_ready = 1'b1;
    tick;
    mul_ready = 1'b0;
    flush = 1'b1; mul_out_valid = 1'b1; mul_result_lo = 64'd42;
    #1;
    check("wait flush mul_flush", 64'(mul_flush), 64'd1);
    check("wait flush in_ready", 64'(in_ready), 64'd0);
    tick;
    flush = 1'b0; mul_out_valid = 1'b0;
    #1;
    check("after flush busy", 64'(busy), 64'd0);
    check("after flush out_valid", 64'(out_valid), 64'd0);
    check("after flush out_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(2'b00, 64'd11, 64'd13, 5'd2, 0, 1, 0, 64'd11, 64'd13, 64'd143, "post-flush");

    // reset asserted mid-op
    in_valid = 1'b1; in_op = 2'b00; in_src1 = 64'h55; in_src2 = 64'h66; in_rd = 5'd8;
    tick;
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midop rst busy", 64'(busy), 64'd0);
    check("midop rst mul_valid", 64'(mul_valid), 64'd0);
    check("midop rst out_result", out_result, 64'd0);
    check("midop rst multiplicand", mul_multiplicand, 64'd0);
    tick;
    reset = 1'b0;
    tick;
    check("midop rst in_ready", 64'(in_ready), 64'd1);

    // zero operand
`ifdef MUL_ISSUE_ZERO_SKIP_EN
    in_valid = 1'b1; in_op = 2'b00; in_src1 = 64'h77; in_src2 = 64'd0; in_rd = 5'd14;
    tick;
    in_valid = 1'b0;
    #1;
    check("zskip out_valid T+1", 64'(out_valid), 64'd1);
    check("zskip mul_valid", 64'(mul_valid), 64'd0);
    check("zskip out_result", out_result, 64'd0);
    check("zskip out_rd", 64'(out_rd), 64'd14);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("zskip in_ready", 64'(in_ready), 64'd1);
    check("zskip mul_valid after", 64'(mul_valid), 64'd0);
`else
    do_op(2'b00, 64'h77, 64'd0, 5'd14, 0, 1, 0, 64'h77, 64'd0, 64'd0, "zero-op");
`endif

    // randomized ops against the reference model; nonzero operands
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_s1 = {$urandom, $urandom} | 64'd1;
      r_s2 = {$urandom, $urandom} | 64'd1;
      r_rd = 5'($urandom_range(0, 31));
      do_op(r_op, r_s1, r_s2, r_rd, $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 3), ref_operand(r_op, r_s1), ref_operand(r_op, r_s2),
            ref_result(r_op, r_s1, r_s2), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
